// File: rtl/gte_mul_sequencer_pkg.sv
// gte_seq_pkg: shared types and constants for the GTE multiply-select sequencer.
//   - supported GTE opcodes
//   - left/right operand-mux codes
//   - gteStepWord: one selector word as issued to the multiply datapath
//   - FSM state encoding
package gte_seq_pkg;

    localparam logic [5:0] OP_RTPS  = 6'h01;
    localparam logic [5:0] OP_NCLIP = 6'h06;
    localparam logic [5:0] OP_DPCS  = 6'h10;
    localparam logic [5:0] OP_MVMVA = 6'h12;
    localparam logic [5:0] OP_SQR   = 6'h28;
    localparam logic [5:0] OP_AVSZ3 = 6'h2D;
    localparam logic [5:0] OP_AVSZ4 = 6'h2E;

    // left operand codes
    localparam logic [3:0] L_MAT0  = 4'd0;
    localparam logic [3:0] L_MAT1  = 4'd1;
    localparam logic [3:0] L_MAT2  = 4'd2;
    localparam logic [3:0] L_COLOR = 4'd3;
    localparam logic [3:0] L_IRN   = 4'd4;
    localparam logic [3:0] L_SZ    = 4'd5;
    localparam logic [3:0] L_DQA   = 4'd6;
    localparam logic [3:0] L_4096  = 4'd7;
    localparam logic [3:0] L_SX    = 4'd8;

    // right operand codes
    localparam logic [3:0] R_VCOMP = 4'd0;
    localparam logic [3:0] R_TMP   = 4'd1;
    localparam logic [3:0] R_Z3    = 4'd2;
    localparam logic [3:0] R_Z4    = 4'd3;
    localparam logic [3:0] R_ZERO  = 4'd4;
    localparam logic [3:0] R_IRN   = 4'd5;
    localparam logic [3:0] R_IR0   = 4'd6;
    localparam logic [3:0] R_COLOR = 4'd7;
    localparam logic [3:0] R_SYA   = 4'd8;
    localparam logic [3:0] R_SYB   = 4'd9;

    typedef struct packed {
        logic [1:0] mat;
        logic [1:0] vcompo;
        logic [3:0] selLeft;
        logic [3:0] selRight;
        logic       isMVMVA;
        logic       last;
    } gteStepWord;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ERR} gte_seq_state_e;

endpackage

// File: rtl/gte_mul_sequencer_if.sv
// gte_mul_sequencer_if: command/selector bundle between the GTE command decoder
// (master) and the multiply-select sequencer (slave).
//   i_start/i_opcode/i_mx/i_vec : command request and MVMVA overrides
//   i_stall                     : datapath hold
//   o_busy/o_valid/o_step/o_last: sequencing status
//   o_mat/o_vcompo/o_selLeft/o_selRight/o_isMVMVA : selector word
//   o_done/o_err                : completion pulse / unsupported-opcode flag
interface gte_mul_sequencer_if;
    logic       i_start;
    logic [5:0] i_opcode;
    logic [1:0] i_mx;
    logic [1:0] i_vec;
    logic       i_stall;
    logic       o_busy;
    logic       o_valid;
    logic       o_isMVMVA;
    logic [1:0] o_mat;
    logic [1:0] o_vcompo;
    logic [3:0] o_selLeft;
    logic [3:0] o_selRight;
    logic [2:0] o_step;
    logic       o_last;
    logic       o_done;
    logic       o_err;

    modport master (
        output i_start, i_opcode, i_mx, i_vec, i_stall,
        input  o_busy, o_valid, o_isMVMVA, o_mat, o_vcompo, o_selLeft, o_selRight,
               o_step, o_last, o_done, o_err
    );

    modport slave (
        input  i_start, i_opcode, i_mx, i_vec, i_stall,
        output o_busy, o_valid, o_isMVMVA, o_mat, o_vcompo, o_selLeft, o_selRight,
               o_step, o_last, o_done, o_err
    );
endinterface

// File: rtl/gte_mul_sequencer_rom.sv
// gte_seq_rom: combinational step table.
//   in : opcode, step index, MVMVA mx/vec overrides
//   out: word (selector word for that step, zero past the last step),
//        supported (opcode is one the sequencer knows)
module gte_seq_rom
    import gte_seq_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [2:0] step,
    input  logic [1:0] mx,
    input  logic [1:0] vec,
    output gteStepWord word,
    output logic       supported
);
    always_comb begin
        word      = '0;
        supported = 1'b1;
        case (opcode)
            OP_MVMVA: if (step <= 3'd2) begin
                word.selLeft  = {1'b0, step};     // MAT column 0..2
                word.selRight = R_VCOMP;
                word.mat      = mx;
                word.vcompo   = vec;
                word.isMVMVA  = 1'b1;
                word.last     = (step == 3'd2);
            end
            OP_RTPS: begin
                if (step <= 3'd2) begin
                    word.selLeft  = {1'b0, step};
                    word.selRight = R_VCOMP;
                end else if (step == 3'd3) begin
                    word.selLeft  = L_DQA;
                    word.selRight = R_TMP;
                    word.last     = 1'b1;
                end
            end
            OP_NCLIP: begin
                if (step == 3'd0) begin
                    word.selLeft  = L_SX;
                    word.selRight = R_SYA;
                end else if (step == 3'd1) begin
                    word.selLeft  = L_SX;
                    word.selRight = R_SYB;
                    word.last     = 1'b1;
                end
            end
            OP_DPCS: begin
                if (step == 3'd0) begin
                    word.selLeft  = L_4096;
                    word.selRight = R_COLOR;
                end else if (step == 3'd1) begin
                    word.selLeft  = L_IRN;
                    word.selRight = R_IR0;
                    word.last     = 1'b1;
                end
            end
            OP_SQR: if (step == 3'd0) begin
                word.selLeft  = L_IRN;
                word.selRight = R_IRN;
                word.last     = 1'b1;
            end
            OP_AVSZ3: if (step == 3'd0) begin
                word.selLeft  = L_SZ;
                word.selRight = R_Z3;
                word.last     = 1'b1;
            end
            OP_AVSZ4: if (step == 3'd0) begin
                word.selLeft  = L_SZ;
                word.selRight = R_Z4;
                word.last     = 1'b1;
            end
            default: supported = 1'b0;
        endcase
    end
endmodule

// File: rtl/gte_mul_sequencer.sv
// gte_mul_sequencer: issues one selector word per unstalled cycle for each
// accepted GTE command, then waits P_DRAIN cycles for the multiplier pipeline
// before pulsing o_done. Unsupported opcodes finish in one cycle with o_err.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : gte_mul_sequencer_if.slave (command in, selector word out)
module gte_mul_sequencer
    import gte_seq_pkg::*;
#(
    parameter int P_DRAIN = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    gte_mul_sequencer_if.slave    bus
);
    gte_seq_state_e state_q, state_d;
    logic [5:0]     op_q;
    logic [1:0]     mx_q, vec_q;
    logic [2:0]     step_q, drain_q;
    gteStepWord     word_q;

    logic [5:0]     rom_op;
    logic [1:0]     rom_mx, rom_vec;
    logic [2:0]     rom_step;
    gteStepWord     rom_word;
    logic           rom_ok;

    logic accept, advance, drain_done;

    assign accept     = (state_q == IDLE)  && bus.i_start;
    assign advance    = (state_q == ISSUE) && !bus.i_stall;
    assign drain_done = (state_q == DRAIN) && (drain_q == 3'(P_DRAIN));

    // One table lookup: in IDLE it decodes the incoming command (step 0),
    // otherwise it looks ahead to the step after the one being presented.
    always_comb begin
        if (state_q == IDLE) begin
            rom_op   = bus.i_opcode;
            rom_mx   = bus.i_mx;
            rom_vec  = bus.i_vec;
            rom_step = 3'd0;
        end else begin
            rom_op   = op_q;
            rom_mx   = mx_q;
            rom_vec  = vec_q;
            rom_step = step_q + 3'd1;
        end
    end

    gte_seq_rom u_rom (
        .opcode    (rom_op),
        .step      (rom_step),
        .mx        (rom_mx),
        .vec       (rom_vec),
        .word      (rom_word),
        .supported (rom_ok)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = rom_ok ? ISSUE : ERR;
            ISSUE:   if (advance && word_q.last) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_q    <= '0;
            mx_q    <= '0;
            vec_q   <= '0;
            step_q  <= '0;
            drain_q <= '0;
            word_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q    <= bus.i_opcode;
                    mx_q    <= bus.i_mx;
                    vec_q   <= bus.i_vec;
                    step_q  <= '0;
                    drain_q <= '0;
                    word_q  <= rom_word;   // already zero for unsupported opcodes
                end
                ISSUE: if (advance) begin
                    if (word_q.last) begin
                        // selector outputs go quiet while draining
                        step_q <= '0;
                        word_q <= '0;
                    end else begin
                        step_q <= step_q + 3'd1;
                        word_q <= rom_word;
                    end
                end
                DRAIN: if (!bus.i_stall && !drain_done) drain_q <= drain_q + 3'd1;
                default: ;
            endcase
        end
    end

    assign bus.o_busy     = (state_q != IDLE);
    assign bus.o_valid    = advance;
    assign bus.o_isMVMVA  = word_q.isMVMVA;
    assign bus.o_mat      = word_q.mat;
    assign bus.o_vcompo   = word_q.vcompo;
    assign bus.o_selLeft  = word_q.selLeft;
    assign bus.o_selRight = word_q.selRight;
    assign bus.o_step     = step_q;
    assign bus.o_last     = word_q.last;
    assign bus.o_done     = drain_done || (state_q == ERR);
    assign bus.o_err      = (state_q == ERR);
endmodule

// File: tb/tb_gte_mul_sequencer.sv
// Scoreboard bench: stimulus pushes the expected selector/done events (with
// their cycle numbers) into a queue; per-DUT monitors pop and compare whenever
// o_valid or o_done is seen. u_dut uses P_DRAIN=2, u_dut0 uses P_DRAIN=0.
module tb_gte_mul_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gte_mul_sequencer_if b1();
    gte_mul_sequencer_if b2();

    gte_mul_sequencer #(.P_DRAIN(2)) u_dut  (.i_clk(clk), .i_rst(rst), .bus(b1));
    gte_mul_sequencer #(.P_DRAIN(0)) u_dut0 (.i_clk(clk), .i_rst(rst), .bus(b2));

    typedef struct packed {
        logic       v, d, e;
        logic [2:0] st;
        logic [3:0] l, r;
        logic [1:0] m, vc;
        logic       mv, last;
    } ev_t;

    typedef struct {
        ev_t w;
        int  cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    ev_t  a1, a2;
    exp_t e1, e2;

    function automatic ev_t vld(logic [2:0] st, logic [3:0] l, logic [3:0] r,
                                logic [1:0] m, logic [1:0] vc, logic mv, logic last);
        return {1'b1, 1'b0, 1'b0, st, l, r, m, vc, mv, last};
    endfunction

    function automatic ev_t dn(logic err);
        return {1'b0, 1'b1, err, 3'd0, 4'd0, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0};
    endfunction

    function automatic void push(bit which, int c, ev_t w);
        exp_t e;
        e.w   = w;
        e.cyc = c;
        if (which) q2.push_back(e);
        else       q1.push_back(e);
    endfunction

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && (b1.o_valid || b1.o_done)) begin
            a1 = {b1.o_valid, b1.o_done, b1.o_err, b1.o_step, b1.o_selLeft, b1.o_selRight,
                  b1.o_mat, b1.o_vcompo, b1.o_isMVMVA, b1.o_last};
            n_run++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL dut2_unexpected cyc=%0d got=%h want=nothing", cyc, a1);
            end else begin
                e1 = q1.pop_front();
                if (a1 !== e1.w || cyc != e1.cyc) begin
                    n_fail++;
                    $display("FAIL dut2_event got cyc=%0d %h want cyc=%0d %h", cyc, a1, e1.cyc, e1.w);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (b2.o_valid || b2.o_done)) begin
            a2 = {b2.o_valid, b2.o_done, b2.o_err, b2.o_step, b2.o_selLeft, b2.o_selRight,
                  b2.o_mat, b2.o_vcompo, b2.o_isMVMVA, b2.o_last};
            n_run++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL dut0_unexpected cyc=%0d got=%h want=nothing", cyc, a2);
            end else begin
                e2 = q2.pop_front();
                if (a2 !== e2.w || cyc != e2.cyc) begin
                    n_fail++;
                    $display("FAIL dut0_event got cyc=%0d %h want cyc=%0d %h", cyc, a2, e2.cyc, e2.w);
                end
            end
        end
    end

    // inputs change 1 time unit after the rising edge; checks happen at the falling edge
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd1(logic [5:0] op, logic [1:0] mx, logic [1:0] vec);
        b1.i_start  = 1'b1;
        b1.i_opcode = op;
        b1.i_mx     = mx;
        b1.i_vec    = vec;
    endtask

    function automatic logic [31:0] outs1();
        return {12'd0, b1.o_busy, b1.o_valid, b1.o_done, b1.o_err, b1.o_step, b1.o_selLeft,
                b1.o_selRight, b1.o_mat, b1.o_vcompo, b1.o_isMVMVA, b1.o_last};
    endfunction

    function automatic logic [31:0] outs2();
        return {12'd0, b2.o_busy, b2.o_valid, b2.o_done, b2.o_err, b2.o_step, b2.o_selLeft,
                b2.o_selRight, b2.o_mat, b2.o_vcompo, b2.o_isMVMVA, b2.o_last};
    endfunction

    initial begin
        int c0;
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b1;
        {b1.i_start, b1.i_opcode, b1.i_mx, b1.i_vec, b1.i_stall} = '0;
        {b2.i_start, b2.i_opcode, b2.i_mx, b2.i_vec, b2.i_stall} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs_dut2", outs1(), 32'd0);
        chk("reset_outs_dut0", outs2(), 32'd0);
        next_cyc();
        rst = 1'b0;
        repeat (2) next_cyc();

        // 1: MVMVA mx=1 vec=2
        c0 = cyc;
        cmd1(6'h12, 2'd1, 2'd2);
        push(0, c0 + 1, vld(3'd0, 4'd0, 4'd0, 2'd1, 2'd2, 1'b1, 1'b0));
        push(0, c0 + 2, vld(3'd1, 4'd1, 4'd0, 2'd1, 2'd2, 1'b1, 1'b0));
        push(0, c0 + 3, vld(3'd2, 4'd2, 4'd0, 2'd1, 2'd2, 1'b1, 1'b1));
        push(0, c0 + 6, dn(1'b0));
        next_cyc();
        b1.i_start = 1'b0;
        @(negedge clk);
        chk("mvmva_busy", {31'd0, b1.o_busy}, 32'd1);
        repeat (7) next_cyc();

        // 2: RTPS with a 2-cycle stall on step 1
        c0 = cyc;
        cmd1(6'h01, 2'd3, 2'd3);
        push(0, c0 + 1, vld(3'd0, 4'd0, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0));
        push(0, c0 + 4, vld(3'd1, 4'd1, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0));
        push(0, c0 + 5, vld(3'd2, 4'd2, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0));
        push(0, c0 + 6, vld(3'd3, 4'd6, 4'd1, 2'd0, 2'd0, 1'b0, 1'b1));
        push(0, c0 + 9, dn(1'b0));
        next_cyc();
        b1.i_start = 1'b0;
        next_cyc();
        b1.i_stall = 1'b1;
        next_cyc();
        @(negedge clk);
        chk("stall_hold", {24'd0, b1.o_valid, b1.o_step, b1.o_selLeft}, {24'd0, 1'b0, 3'd1, 4'd1});
        next_cyc();
        b1.i_stall = 1'b0;
        repeat (7) next_cyc();

        // 3: SQR, then a held start (MVMVA) while busy and through the done cycle
        c0 = cyc;
        cmd1(6'h28, 2'd0, 2'd0);
        push(0, c0 + 1, vld(3'd0, 4'd4, 4'd5, 2'd0, 2'd0, 1'b0, 1'b1));
        push(0, c0 + 4, dn(1'b0));
        next_cyc();
        cmd1(6'h12, 2'd2, 2'd1);
        repeat (3) next_cyc();
        next_cyc();
        b1.i_start = 1'b0;
        @(negedge clk);
        chk("sqr_idle_after_done", {31'd0, b1.o_busy}, 32'd0);
        repeat (5) next_cyc();

        // 4: unsupported opcode
        c0 = cyc;
        cmd1(6'h3F, 2'd0, 2'd0);
        push(0, c0 + 1, dn(1'b1));
        next_cyc();
        b1.i_start = 1'b0;
        @(negedge clk);
        chk("err_busy_c1", {31'd0, b1.o_busy}, 32'd1);
        next_cyc();
        @(negedge clk);
        chk("err_busy_c2", {31'd0, b1.o_busy}, 32'd0);
        repeat (3) next_cyc();

        // 5: reset during DPCS step 1, then AVSZ4
        c0 = cyc;
        cmd1(6'h10, 2'd0, 2'd0);
        push(0, c0 + 1, vld(3'd0, 4'd7, 4'd7, 2'd0, 2'd0, 1'b0, 1'b0));
        next_cyc();
        b1.i_start = 1'b0;
        next_cyc();
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_outs_zero", outs1(), 32'd0);
        repeat (6) next_cyc();
        c0 = cyc;
        cmd1(6'h2E, 2'd0, 2'd0);
        push(0, c0 + 1, vld(3'd0, 4'd5, 4'd3, 2'd0, 2'd0, 1'b0, 1'b1));
        push(0, c0 + 4, dn(1'b0));
        next_cyc();
        b1.i_start = 1'b0;
        repeat (6) next_cyc();

        // 6: P_DRAIN=0 instance, AVSZ3
        c0 = cyc;
        b2.i_start  = 1'b1;
        b2.i_opcode = 6'h2D;
        push(1, c0 + 1, vld(3'd0, 4'd5, 4'd2, 2'd0, 2'd0, 1'b0, 1'b1));
        push(1, c0 + 2, dn(1'b0));
        next_cyc();
        b2.i_start = 1'b0;
        repeat (5) next_cyc();
        @(negedge clk);
        chk("dut0_idle_end", {31'd0, b2.o_busy}, 32'd0);

        chk("scoreboard_empty", 32'(q1.size() + q2.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
